data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests.
- Takes the requests the pipeline issues (Address, Write_Data, MemRead, MemWrite).
- Models a backing store with fixed access latency.
- Holds the pipeline with Mem_Stall until the access completes.
- Returns read data with a one-cycle Mem_Ready pulse.
- Flags misaligned, out-of-range and conflicting requests without touching storage.

Parameters:
DEPTH_LOG2, 8, log2 of storage depth in 32-bit words (256 words, byte addresses 0x000-0x3FC).
LATENCY, 3, BUSY cycles per legal access; legal range 1-15.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
Address  input  32  byte address from EX/MEM register (MEM_ALU_RESULT).
Write_Data  input  32  store data (MEM_RT_DATA).
MemRead  input  1  load request.
MemWrite  input  1  store request.
Read_data  output  32  load result; valid when Mem_Ready=1, held otherwise.
Mem_Stall  output  1  combinational; freeze PC, IF/ID, ID/EX, EX/MEM while high.
Mem_Ready  output  1  one-cycle completion pulse.
Addr_Error  output  1  one-cycle pulse coincident with Mem_Ready for a rejected request.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - state=IDLE; counter=0; Read_data=0; Mem_Ready=0; Addr_Error=0.
  - All storage words cleared to 0.
  - Any latched request is discarded; a pending write never commits.
  - Mem_Stall=0 in the cycle after reset.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req = MemRead|MemWrite.
  - Mem_Stall = req (combinational, same cycle).
  - On an edge with req, latch Address, Write_Data and op.
  - Legal request: go to BUSY with counter=LATENCY-1.
  - Illegal request: go directly to DONE with err=1. Illegal means any of:
    - Address[1:0]!=0;
    - Address[31:DEPTH_LOG2+2]!=0;
    - MemRead&MemWrite.
- BUSY:
  - Mem_Stall=1; inputs ignored.
  - Counter decrements each cycle.
  - On the edge where counter==0, perform the access and go to DONE:
    - write: store latched data at word index Address[DEPTH_LOG2+1:2];
    - read: load word into Read_data.
- DONE:
  - Mem_Stall=0; Mem_Ready=1; Addr_Error=err.
  - Inputs ignored (the request is still present while the pipeline advances at the end of this cycle, so it must not be re-executed).
  - Next state IDLE.
- Latency for a legal access, request first visible in cycle 0:
  - Mem_Stall high in cycles 0..LATENCY;
  - Mem_Ready in cycle LATENCY+1;
  - next request accepted from cycle LATENCY+2.
- Latency for an illegal access: Mem_Stall high in cycle 0 only; Mem_Ready=Addr_Error=1 in cycle 1.
- Errors:
  - Storage unchanged.
  - Read_data forced to 0 on an erroneous read.
  - Read_data unchanged on an erroneous write.
- Read_data changes only on a completed read, an erroneous read, or reset.
- Write then immediate read of the same word returns the new data; no bypass is needed because the accesses are serialized.
- With no request in IDLE, all pulses stay 0 and Mem_Stall=0.

Test Plan:
1. Assert RESET 2 cycles -> Read_data=0, Mem_Stall=0, Mem_Ready=0, Addr_Error=0; a read of 0x3FC returns 0.
2. LATENCY=3: MemWrite, Address=0x10, Write_Data=0xDEADBEEF held until ready -> Mem_Stall=1 in cycles 0-3, Mem_Ready in cycle 4, Addr_Error=0. Then MemRead 0x10 -> Read_data=0xDEADBEEF with Mem_Ready in cycle 4.
3. MemRead, Address=0x12 -> Mem_Stall=1 one cycle; next cycle Mem_Ready=Addr_Error=1 and Read_data=0. Also MemRead=MemWrite=1 at 0x20 -> Addr_Error=1, word 0x20 unchanged.
4. MemWrite, Address=0x400, data 0x12345678 -> Addr_Error=1. Subsequent reads of 0x000 and 0x3FC return 0 (no aliasing).
5. MemWrite 0x40 = 0xA5A5A5A5; assert RESET in BUSY cycle 2 -> next cycle IDLE, Mem_Stall=0, Mem_Ready never pulses, read of 0x40 returns 0.
6. Request inputs held stable through DONE, then new MemRead 0x10 in the following cycle -> exactly one write commits, one Mem_Ready per request, second request starts stalling on the cycle it appears.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        Mem_Stall;
  logic        Mem_Ready;
  logic        Addr_Error;

  modport master (
    output Address, Write_Data, MemRead, MemWrite,
    input  Read_data, Mem_Stall, Mem_Ready, Addr_Error
  );

  modport slave (
    input  Address, Write_Data, MemRead, MemWrite,
    output Read_data, Mem_Stall, Mem_Ready, Addr_Error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: serializes MEM-stage loads/stores against a
// word-addressed store with fixed latency, stalling the pipeline until done.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             mem_q [DEPTH];

  logic req;
  logic illegal;
  logic stall;
  logic mem_we;

  assign req     = bus.MemRead | bus.MemWrite;
  assign illegal = (bus.Address[1:0] != 2'b00)
                 || (bus.Address[31:DEPTH_LOG2+2] != '0)
                 || (bus.MemRead & bus.MemWrite);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          idx_d   = bus.Address[DEPTH_LOG2+1:2];
          wdata_d = bus.Write_Data;
          wr_d    = bus.MemWrite;
          if (illegal) begin
            // Rejected requests skip the store entirely; a rejected load reads as zero.
            err_d   = 1'b1;
            state_d = DONE;
            if (bus.MemRead) begin
              rdata_d = '0;
            end
          end else begin
            err_d   = 1'b0;
            cnt_d   = 4'(LATENCY - 1);
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        // Request is still on the bus this cycle; it must not be re-accepted.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Whole store clears on reset, so it lives in registers rather than block RAM.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.Mem_Stall  = stall;
  assign bus.Mem_Ready  = (state_q == DONE);
  assign bus.Addr_Error = (state_q == DONE) & err_q;
  assign bus.Read_data  = rdata_q;

endmodule
